fetch_unit: RTL and testbench

- PC register and instruction register (IR) stage that sits directly upstream of the multi-cycle control FSM.
- Computes the next PC from the control outputs `pc_src`/`pc_wre`, the IR fields and the `jr` register operand.
- Runs a request/acknowledge handshake to instruction memory, which has variable latency.
- Presents the IR opcode and fields to control and decode, and tells control when a fetched word is ready, so control can stall its fetch/decode states.

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// PC/IR fetch stage with a variable-latency req/ack handshake to instruction memory.
// Optional macro FETCH_ALIGN_CHECK_EN: flag misaligned jr targets on align_err.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] IR_RESET = 32'hFC00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_wre,
  input  logic [1:0]  pc_src,
  input  logic        ir_wre,
  input  logic [31:0] rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        proto_err,
  output logic        align_err
);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_VALID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] buf_q, buf_d;
  logic        boot_q, boot_d;
  logic        proto_err_q, proto_err_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] imm_ext;
  logic [31:0] next_pc;
  logic        commit;

  assign pc_plus4_w = pc_q + 32'd4;
  assign imm_ext    = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4_w;
    case (pc_src)
      2'b00:   next_pc = pc_plus4_w;
      2'b01:   next_pc = pc_plus4_w + imm_ext;
      2'b10:   next_pc = rs_data & 32'hFFFF_FFFC;
      default: next_pc = {pc_plus4_w[31:28], ir_q[25:0], 2'b00};
    endcase
  end

  // A pc_wre only commits a new PC once the boot fetch has been consumed.
  assign commit = (state_q == F_IDLE) && pc_wre && !boot_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    buf_d       = buf_q;
    boot_d      = boot_q;
    proto_err_d = proto_err_q;
    case (state_q)
      F_REQ: begin
        if (imem_ack) begin
          buf_d   = imem_rdata;
          state_d = F_VALID;
        end
      end
      F_VALID: begin
        if (ir_wre) begin
          ir_d    = buf_q;
          state_d = F_IDLE;
        end
      end
      default: begin
        if (pc_wre) begin
          if (boot_q) boot_d = 1'b0;
          else        pc_d   = next_pc;
          state_d = F_REQ;
        end
      end
    endcase
    if ((pc_wre && state_q != F_IDLE) || (ir_wre && state_q != F_VALID))
      proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= F_REQ;
      pc_q        <= RESET_PC;
      ir_q        <= IR_RESET;
      buf_q       <= 32'd0;
      boot_q      <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      buf_q       <= buf_d;
      boot_q      <= boot_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;

  always_comb begin
    align_err_d = align_err_q;
    if (commit && pc_src == 2'b10 && rs_data[1:0] != 2'b00)
      align_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) align_err_q <= 1'b0;
    else     align_err_q <= align_err_d;
  end

  assign align_err = align_err_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign align_err     = 1'b0;
`endif

  assign imem_req    = (state_q == F_REQ);
  assign imem_addr   = pc_q;
  assign fetch_ready = (state_q == F_VALID);
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign ir          = ir_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard queues hold expected fetch addresses and IR words.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_wre = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        ir_wre = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        fetch_ready;
  logic [31:0] pc, pc_plus4, ir;
  logic        proto_err, align_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_ir_q[$];

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_wre(pc_wre), .pc_src(pc_src), .ir_wre(ir_wre),
    .rs_data(rs_data), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_ready(fetch_ready),
    .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .proto_err(proto_err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory model: wait for a request, check its address against the scoreboard,
  // hold ack low for lat cycles while checking the address stays put, then reply.
  task automatic mem_reply(input int lat, input logic [31:0] word);
    logic [31:0] exp_a;
    logic [31:0] addr0;
    int n;
    n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    checks++;
    if (!imem_req) begin
      errors++;
      $display("FAIL mem_req_timeout: imem_req=%0b required 1", imem_req);
      return;
    end
    exp_a = 32'hDEAD_BEEF;
    if (exp_addr_q.size() > 0) exp_a = exp_addr_q.pop_front();
    checks++;
    if (imem_addr !== exp_a) begin
      errors++;
      $display("FAIL imem_addr: got %h required %h", imem_addr, exp_a);
    end
    addr0 = imem_addr;
    for (int i = 0; i < lat; i++) begin
      tick();
      checks++;
      if (imem_addr !== addr0 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL addr_hold: addr=%h req=%0b required addr=%h req=1", imem_addr, imem_req, addr0);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_ir_q.push_back(word);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    checks++;
    if (fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL fetch_ready: got %0b required 1", fetch_ready);
    end
  endtask

  task automatic load_ir();
    logic [31:0] exp_w;
    ir_wre = 1'b1;
    tick();
    ir_wre = 1'b0;
    exp_w = 32'hDEAD_BEEF;
    if (exp_ir_q.size() > 0) exp_w = exp_ir_q.pop_front();
    checks++;
    if (ir !== exp_w || fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL ir_load: ir=%h ready=%0b required ir=%h ready=0", ir, fetch_ready, exp_w);
    end
  endtask

  task automatic commit(input logic [1:0] src, input logic [31:0] rs, input logic [31:0] exp_pc);
    pc_wre  = 1'b1;
    pc_src  = src;
    rs_data = rs;
    tick();
    pc_wre  = 1'b0;
    pc_src  = 2'b00;
    checks++;
    if (pc !== exp_pc || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL pc_commit src=%0d: pc=%h req=%0b required pc=%h req=1", src, pc, imem_req, exp_pc);
    end
    exp_addr_q.push_back(exp_pc);
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if (pc !== 32'h0 || ir !== 32'hFC00_0000 || imem_req !== 1'b1 || fetch_ready !== 1'b0 ||
        proto_err !== 1'b0 || align_err !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL %s: pc=%h ir=%h req=%0b rdy=%0b perr=%0b aerr=%0b required pc=0 ir=fc000000 req=1 rdy=0 perr=0 aerr=0",
               name, pc, ir, imem_req, fetch_ready, proto_err, align_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    check_reset_state("reset_state");
    rst = 1'b0;
    exp_addr_q.delete();
    exp_ir_q.delete();
    exp_addr_q.push_back(32'h0);
  endtask

  task automatic test_boot();
    mem_reply(3, 32'h0822_0000);
    load_ir();
    commit(2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_seq_branch();
    mem_reply(0, 32'h0000_0000);
    load_ir();
    commit(2'b10, 32'h0000_0040, 32'h0000_0040);
    mem_reply(1, 32'h0000_1234);
    load_ir();
    checks++;
    if (pc_plus4 !== 32'h44) begin
      errors++;
      $display("FAIL pc_plus4: got %h required 00000044", pc_plus4);
    end
    commit(2'b00, 32'h0, 32'h0000_0044);
    mem_reply(2, 32'h0000_0000);
    load_ir();
    commit(2'b10, 32'h0000_0040, 32'h0000_0040);
    mem_reply(0, 32'h1000_FFFE);
    load_ir();
    commit(2'b01, 32'h0, 32'h0000_003C);
  endtask

  task automatic test_jumps();
    logic exp_align;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_align = 1'b1;
`else
    exp_align = 1'b0;
`endif
    mem_reply(1, 32'h0000_0000);
    load_ir();
    commit(2'b10, 32'h1000_0010, 32'h1000_0010);
    mem_reply(0, 32'h0800_0040);
    load_ir();
    commit(2'b11, 32'h0, 32'h1000_0100);
    checks++;
    if (align_err !== 1'b0) begin
      errors++;
      $display("FAIL align_pre: got %0b required 0", align_err);
    end
    mem_reply(0, 32'h0000_0000);
    load_ir();
    commit(2'b10, 32'h0000_0203, 32'h0000_0200);
    checks++;
    if (align_err !== exp_align) begin
      errors++;
      $display("FAIL align_jr: got %0b required %0b", align_err, exp_align);
    end
  endtask

  task automatic test_proto();
    logic [31:0] ir_before;
    pc_wre = 1'b1;
    tick();
    pc_wre = 1'b0;
    checks++;
    if (pc !== 32'h200 || proto_err !== 1'b1 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL pc_wre_in_req: pc=%h perr=%0b req=%0b required pc=00000200 perr=1 req=1", pc, proto_err, imem_req);
    end
    mem_reply(10, 32'hABCD_0123);
    load_ir();
    ir_before = ir;
    ir_wre = 1'b1;
    tick();
    ir_wre = 1'b0;
    checks++;
    if (ir !== 32'hABCD_0123 || ir !== ir_before || pc !== 32'h200 || fetch_ready !== 1'b0 ||
        imem_req !== 1'b0 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL ir_wre_in_idle: ir=%h pc=%h rdy=%0b req=%0b perr=%0b required ir=abcd0123 pc=00000200 rdy=0 req=0 perr=1",
               ir, pc, fetch_ready, imem_req, proto_err);
    end
  endtask

  task automatic test_wrap();
    commit(2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    mem_reply(0, 32'h0000_0000);
    load_ir();
    commit(2'b00, 32'h0, 32'h0000_0000);
    mem_reply(0, 32'h0000_0000);
    load_ir();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: got %0b required 1", proto_err);
    end
  endtask

  task automatic test_reset_mid_fetch();
    commit(2'b10, 32'h0000_0080, 32'h0000_0080);
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      errors++;
      $display("FAIL pre_reset_req: req=%0b addr=%h required req=1 addr=00000080", imem_req, imem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("reset_mid_fetch");
    exp_addr_q.delete();
    exp_ir_q.delete();
    exp_addr_q.push_back(32'h0);
    mem_reply(0, 32'h2000_0001);
    load_ir();
  endtask

  initial begin
    tick();
    test_reset();
    test_boot();
    test_seq_branch();
    test_jumps();
    test_proto();
    test_wrap();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
